// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path.
// Optional build macro used by regfile_wb_arbiter: WB_ARB_FIXED_PRI0_EN.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Next round-robin pointer after serving index g, wrapping to wrap_to.
  function automatic int unsigned rr_next(input int unsigned g,
                                          input int unsigned n,
                                          input int unsigned wrap_to);
    return (g + 1 >= n) ? wrap_to : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first set bit of req at or after
// ptr, wrapping modulo N. Produces one-hot grant and its encoded index.
module rr_priority_picker #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the search order ptr, ptr+1, ... and take the first valid request.
  always_comb begin
    int unsigned pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (j == pos && !any && req[j]) begin
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// write-back sources, with a registered wr_* output stage.
// Build macro WB_ARB_FIXED_PRI0_EN: requester 0 always wins when valid.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [SRC_W-1:0]          wr_src
);

`ifdef WB_ARB_FIXED_PRI0_EN
  localparam int unsigned RST_PTR = 1;
`else
  localparam int unsigned RST_PTR = 0;
`endif

  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [SRC_W-1:0]   wr_src_q, wr_src_d;

  logic [NUM_REQ-1:0] rr_req, rr_grant, grant;
  logic [SRC_W-1:0]   rr_idx, grant_idx;
  logic               rr_any;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

`ifdef WB_ARB_FIXED_PRI0_EN
  // Requester 0 is handled outside the rotation; the picker only sees 1..N-1.
  assign rr_req = req_valid & ~NUM_REQ'(1);
`else
  assign rr_req = req_valid;
`endif

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_picker (
    .req   (rr_req),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Final grant selection, handshake and next-state for the output stage.
  always_comb begin
    grant     = rr_grant;
    grant_idx = rr_idx;
`ifdef WB_ARB_FIXED_PRI0_EN
    if (req_valid[0]) begin
      grant     = NUM_REQ'(1);
      grant_idx = '0;
    end
`endif
    req_ready = (clr || wb_stall) ? '0 : grant;
    xfer      = |req_ready;

    sel_addr = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(grant_idx) == j) begin
        sel_addr = req_addr[j*ADDR_W +: ADDR_W];
        sel_data = req_data[j*DATA_W +: DATA_W];
      end
    end

    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (xfer) begin
      // Writes to r0 are accepted and recorded but never enabled.
      wr_en_d   = (sel_addr != ADDR_W'(ZERO_REG));
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wr_src_d  = grant_idx;
`ifdef WB_ARB_FIXED_PRI0_EN
      if (grant_idx != '0)
        ptr_d = SRC_W'(rr_next(32'(grant_idx), NUM_REQ, RST_PTR));
`else
      ptr_d = SRC_W'(rr_next(32'(grant_idx), NUM_REQ, RST_PTR));
`endif
    end
  end

  // Pointer and registered write port, synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q     <= SRC_W'(RST_PTR);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

endmodule
